pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Parametrised successor to the single-cycle main decoder. Decodes the ID-stage opcode into a
//  12-bit control bundle, then carries it through the ID/EX, EX/MEM and MEM/WB control registers.
//  Resolves the write-register index and detects load-use hazards (stall + bubble).
//  Applies branch/jump flushes and counts illegal opcodes. Sits beside the datapath pipeline registers.
// PARAMETERS
//  REG_AW    5    register-index width
//  LINK_REG  31   destination index forced for jal
//  ILL_CW    8    width of saturating illegal-opcode counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  id_valid   in   1       ID stage holds a real instruction
//  id_opcode  in   6       instr[31:26] in ID
//  id_rs      in   REG_AW  instr[25:21] in ID
//  id_rt      in   REG_AW  instr[20:16] in ID
//  id_rd      in   REG_AW  instr[15:11] in ID
//  stall_ext  in   1       memory stall; freezes all control registers
//  flush      in   1       taken branch/jump; discard the instruction in ID
//  stall_id   out  1       load-use stall; hold PC and IF/ID
//  ctrl_ex    out  12      ID/EX bundle
//  ctrl_mem   out  12      EX/MEM bundle
//  ctrl_wb    out  12      MEM/WB bundle
//  ex_wreg    out  REG_AW  write index, EX stage
//  mem_wreg   out  REG_AW  write index, MEM stage
//  wb_wreg    out  REG_AW  write index, WB stage
//  ex_opcode  out  6       opcode in EX (for ALU control)
//  ill_cnt    out  ILL_CW  illegal-opcode count
// BEHAVIOUR
//  Bundle bit layout [11:0]: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,ALUOp1,ALUOp0,Jump,Link.
//  Decode (no X; every don't-care is 0):
//    R 000000=0x908, lw 100011=0x780, sw 101011=0x440, beq 000100=0x024
//    bne 000101=0x014, j 000010=0x002, jal 000011=0x103.
//    Any other opcode is illegal and decodes to 0x000 (bubble).
//  id_valid=0 decodes to bubble.
//  Write index: Link ? LINK_REG : RegDst ? id_rd : id_rt. Computed in ID and registered with the bundle.
//  Latency: ID decode appears on ctrl_ex after 1 clk, on ctrl_mem after 2, on ctrl_wb after 3.
//  uses_rt = R, sw, beq, bne.
//  hz = id_valid & ctrl_ex.MemRead & ex_wreg!=0 & (ex_wreg==id_rs | (uses_rt & ex_wreg==id_rt)).
//  Priority per clk:
//    1. stall_ext=1: all registers hold; ill_cnt holds; stall_id=0; flush ignored (the source holds flush).
//    2. flush=1: ID/EX <= bubble; EX/MEM, MEM/WB advance; stall_id=0; hz suppressed.
//    3. hz=1: stall_id=1 (combinational); ID/EX <= bubble; EX/MEM, MEM/WB advance.
//       Next cycle hz=0, so the stall lasts exactly 1 clk.
//    4. otherwise: all stages advance.
//  ex_opcode follows ID/EX (bubble -> 0).
//  ill_cnt increments by 1 only on a case-4 advance of an id_valid illegal opcode. It saturates at 2^ILL_CW-1.
//  Reset (async, any time, including mid-stall): ctrl_*=0, *_wreg=0, ex_opcode=0, ill_cnt=0, stall_id=0.
//  Normal operation resumes on the first clk after rst_n rises.
//  ex_wreg==0 never causes a stall.
// CONFIGURATION
//  EXT_IMM_OPS_EN defined:
//    addi 001000, slti 001010, andi 001100, ori 001101 decode to 0x50C (ALUSrc, RegWrite, ALUOp=11).
//    ALUOp=11 means the ALU control decodes ex_opcode. uses_rt=0 for these; write index = rt.
//  EXT_IMM_OPS_EN undefined: these four opcodes are illegal (bubble, counted).
// TESTING
//  T1 rst_n=0 mid-traffic -> all outputs 0 immediately; after release, lw enters -> ctrl_ex=0x780 next clk.
//  T2 lw rt=5, then R rs=5 -> stall_id=1 one clk; ctrl_ex=0x000; then ctrl_ex=0x908; ctrl_wb order lw,bubble,R.
//  T3 lw rt=0, then R rs=0 -> stall_id=0; no bubble.
//  T4 hz and flush in same clk -> stall_id=0; ctrl_ex=0x000.
//     stall_ext=1 for 3 clk -> ctrl_ex, ctrl_mem, ctrl_wb constant.
//  T5 jal rd=7 -> ex_wreg=31, ctrl_ex=0x103; sw -> RegWrite=0, ctrl_ex=0x440.
//  T6 300 valid advances of opcode 111111 -> ill_cnt=255.
//     addi: 0x50C with EXT_IMM_OPS_EN defined, else 0x000 and ill_cnt+1.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined main decoder: decodes the ID opcode into a 12-bit control bundle and carries it through ID/EX, EX/MEM, MEM/WB.
// It also detects load-use hazards and counts illegal opcodes. Define EXT_IMM_OPS_EN to decode addi/slti/andi/ori.
module pipelined_control_unit #(
   parameter int REG_AW   = 5,
   parameter int LINK_REG = 31,
   parameter int ILL_CW   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              stall_ext,
   input  logic              flush,
   output logic              stall_id,
   output logic [11:0]       ctrl_ex,
   output logic [11:0]       ctrl_mem,
   output logic [11:0]       ctrl_wb,
   output logic [REG_AW-1:0] ex_wreg,
   output logic [REG_AW-1:0] mem_wreg,
   output logic [REG_AW-1:0] wb_wreg,
   output logic [5:0]        ex_opcode,
   output logic [ILL_CW-1:0] ill_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // Bundle order: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,ALUOp1,ALUOp0,Jump,Link
   localparam logic [11:0] CW_BUBBLE = 12'h000;
   localparam logic [11:0] CW_RTYPE  = 12'h908;
   localparam logic [11:0] CW_LW     = 12'h780;
   localparam logic [11:0] CW_SW     = 12'h440;
   localparam logic [11:0] CW_BEQ    = 12'h024;
   localparam logic [11:0] CW_BNE    = 12'h014;
   localparam logic [11:0] CW_J      = 12'h002;
   localparam logic [11:0] CW_JAL    = 12'h103;

`ifdef EXT_IMM_OPS_EN
   localparam logic [5:0]  OP_ADDI = 6'b001000;
   localparam logic [5:0]  OP_SLTI = 6'b001010;
   localparam logic [5:0]  OP_ANDI = 6'b001100;
   localparam logic [5:0]  OP_ORI  = 6'b001101;
   localparam logic [11:0] CW_IMM  = 12'h50C;
`endif

   localparam int B_REGDST  = 11;
   localparam int B_MEMREAD = 7;
   localparam int B_LINK    = 0;

   localparam logic [REG_AW-1:0] LINK_IDX = LINK_REG[REG_AW-1:0];
   localparam logic [ILL_CW-1:0] ILL_MAX  = '1;
   localparam logic [ILL_CW-1:0] ILL_ONE  = {{(ILL_CW-1){1'b0}}, 1'b1};

   logic [11:0]       ctrl_ex_q, ctrl_ex_d;
   logic [11:0]       ctrl_mem_q, ctrl_mem_d;
   logic [11:0]       ctrl_wb_q, ctrl_wb_d;
   logic [REG_AW-1:0] ex_wreg_q, ex_wreg_d;
   logic [REG_AW-1:0] mem_wreg_q, mem_wreg_d;
   logic [REG_AW-1:0] wb_wreg_q, wb_wreg_d;
   logic [5:0]        ex_opcode_q, ex_opcode_d;
   logic [ILL_CW-1:0] ill_cnt_q, ill_cnt_d;

   logic [11:0]       id_cw;
   logic              id_legal;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_wreg;
   logic [5:0]        id_op_fwd;
   logic              hz;

   always_comb begin
      id_cw      = CW_BUBBLE;
      id_legal   = 1'b1;
      id_uses_rt = 1'b0;
      case (id_opcode)
         OP_RTYPE: begin
            id_cw      = CW_RTYPE;
            id_uses_rt = 1'b1;
         end
         OP_LW:  id_cw = CW_LW;
         OP_SW: begin
            id_cw      = CW_SW;
            id_uses_rt = 1'b1;
         end
         OP_BEQ: begin
            id_cw      = CW_BEQ;
            id_uses_rt = 1'b1;
         end
         OP_BNE: begin
            id_cw      = CW_BNE;
            id_uses_rt = 1'b1;
         end
         OP_J:   id_cw = CW_J;
         OP_JAL: id_cw = CW_JAL;
`ifdef EXT_IMM_OPS_EN
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: id_cw = CW_IMM;
`endif
         default: id_legal = 1'b0;
      endcase
      if (!id_valid) begin
         id_cw = CW_BUBBLE;
      end
   end

   // A bubble is all-zero: no write index and no opcode reach EX, so it can never look like a producer.
   always_comb begin
      id_wreg   = '0;
      id_op_fwd = 6'b000000;
      if (id_cw != CW_BUBBLE) begin
         id_op_fwd = id_opcode;
         if (id_cw[B_LINK]) begin
            id_wreg = LINK_IDX;
         end else if (id_cw[B_REGDST]) begin
            id_wreg = id_rd;
         end else begin
            id_wreg = id_rt;
         end
      end
   end

   assign hz = id_valid & ctrl_ex_q[B_MEMREAD] & (ex_wreg_q != '0) &
               ((ex_wreg_q == id_rs) | (id_uses_rt & (ex_wreg_q == id_rt)));

   // A memory stall outranks a flush, which outranks a load-use stall.
   always_comb begin
      ctrl_ex_d   = ctrl_ex_q;
      ctrl_mem_d  = ctrl_mem_q;
      ctrl_wb_d   = ctrl_wb_q;
      ex_wreg_d   = ex_wreg_q;
      mem_wreg_d  = mem_wreg_q;
      wb_wreg_d   = wb_wreg_q;
      ex_opcode_d = ex_opcode_q;
      ill_cnt_d   = ill_cnt_q;
      stall_id    = 1'b0;
      if (!stall_ext) begin
         ctrl_wb_d  = ctrl_mem_q;
         wb_wreg_d  = mem_wreg_q;
         ctrl_mem_d = ctrl_ex_q;
         mem_wreg_d = ex_wreg_q;
         if (flush || hz) begin
            ctrl_ex_d   = CW_BUBBLE;
            ex_wreg_d   = '0;
            ex_opcode_d = 6'b000000;
            stall_id    = hz & ~flush;
         end else begin
            ctrl_ex_d   = id_cw;
            ex_wreg_d   = id_wreg;
            ex_opcode_d = id_op_fwd;
            if (id_valid && !id_legal && (ill_cnt_q != ILL_MAX)) begin
               ill_cnt_d = ill_cnt_q + ILL_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_ex_q   <= CW_BUBBLE;
         ctrl_mem_q  <= CW_BUBBLE;
         ctrl_wb_q   <= CW_BUBBLE;
         ex_wreg_q   <= '0;
         mem_wreg_q  <= '0;
         wb_wreg_q   <= '0;
         ex_opcode_q <= 6'b000000;
         ill_cnt_q   <= '0;
      end else begin
         ctrl_ex_q   <= ctrl_ex_d;
         ctrl_mem_q  <= ctrl_mem_d;
         ctrl_wb_q   <= ctrl_wb_d;
         ex_wreg_q   <= ex_wreg_d;
         mem_wreg_q  <= mem_wreg_d;
         wb_wreg_q   <= wb_wreg_d;
         ex_opcode_q <= ex_opcode_d;
         ill_cnt_q   <= ill_cnt_d;
      end
   end

   assign ctrl_ex   = ctrl_ex_q;
   assign ctrl_mem  = ctrl_mem_q;
   assign ctrl_wb   = ctrl_wb_q;
   assign ex_wreg   = ex_wreg_q;
   assign mem_wreg  = mem_wreg_q;
   assign wb_wreg   = wb_wreg_q;
   assign ex_opcode = ex_opcode_q;
   assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit: directed scenarios plus randomized traffic checked against a
// behavioural pipeline model. Honours EXT_IMM_OPS_EN the same way the design does.
module tb_pipelined_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        idValid;
   logic [5:0]  idOpcode;
   logic [4:0]  idRs, idRt, idRd;
   logic        stallExt, flushIn;
   logic        stallId;
   logic [11:0] ctrlEx, ctrlMem, ctrlWb;
   logic [4:0]  exWreg, memWreg, wbWreg;
   logic [5:0]  exOpcode;
   logic [7:0]  illCnt;

   int checks = 0;
   int errors = 0;

   // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
   logic [11:0] mCtrl [3];
   logic [4:0]  mWreg [3];
   logic [5:0]  mOp;
   int          mIll;

   pipelined_control_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_valid  (idValid),
      .id_opcode (idOpcode),
      .id_rs     (idRs),
      .id_rt     (idRt),
      .id_rd     (idRd),
      .stall_ext (stallExt),
      .flush     (flushIn),
      .stall_id  (stallId),
      .ctrl_ex   (ctrlEx),
      .ctrl_mem  (ctrlMem),
      .ctrl_wb   (ctrlWb),
      .ex_wreg   (exWreg),
      .mem_wreg  (memWreg),
      .wb_wreg   (wbWreg),
      .ex_opcode (exOpcode),
      .ill_cnt   (illCnt)
   );

   always #5 clk = ~clk;

   // Opcode to control-bundle lookup table
   function automatic logic [11:0] refDecode(input logic [5:0] op);
      case (op)
         6'h00: return 12'h908;
         6'h23: return 12'h780;
         6'h2b: return 12'h440;
         6'h04: return 12'h024;
         6'h05: return 12'h014;
         6'h02: return 12'h002;
         6'h03: return 12'h103;
`ifdef EXT_IMM_OPS_EN
         6'h08, 6'h0a, 6'h0c, 6'h0d: return 12'h50c;
`endif
         default: return 12'h000;
      endcase
   endfunction

   function automatic bit usesRt(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < 3; i++) begin
         mCtrl[i] = 12'h000;
         mWreg[i] = 5'd0;
      end
      mOp  = 6'd0;
      mIll = 0;
   endtask

   task automatic compareAll(input bit expStall);
      checkOutput("stall_id",  32'(stallId),  32'(expStall));
      checkOutput("ctrl_ex",   32'(ctrlEx),   32'(mCtrl[0]));
      checkOutput("ctrl_mem",  32'(ctrlMem),  32'(mCtrl[1]));
      checkOutput("ctrl_wb",   32'(ctrlWb),   32'(mCtrl[2]));
      checkOutput("ex_wreg",   32'(exWreg),   32'(mWreg[0]));
      checkOutput("mem_wreg",  32'(memWreg),  32'(mWreg[1]));
      checkOutput("wb_wreg",   32'(wbWreg),   32'(mWreg[2]));
      checkOutput("ex_opcode", 32'(exOpcode), 32'(mOp));
      checkOutput("ill_cnt",   32'(illCnt),   32'(mIll));
   endtask

   // Drives one ID-stage cycle, checks the state left by the previous edge, then advances the model
   task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input bit se, input bit fl);
      bit          hz;
      bit          expStall;
      logic [11:0] dec;
      logic [4:0]  wr;
      @(negedge clk);
      idValid  = v;
      idOpcode = op;
      idRs     = rs;
      idRt     = rt;
      idRd     = rd;
      stallExt = se;
      flushIn  = fl;
      #1;
      hz = v && mCtrl[0][7] && (mWreg[0] != 5'd0) &&
           ((mWreg[0] == rs) || (usesRt(op) && (mWreg[0] == rt)));
      expStall = !se && !fl && hz;
      compareAll(expStall);
      if (!se) begin
         dec = v ? refDecode(op) : 12'h000;
         wr  = (dec == 12'h000) ? 5'd0 : (dec[0] ? 5'd31 : (dec[11] ? rd : rt));
         mCtrl[2] = mCtrl[1];
         mWreg[2] = mWreg[1];
         mCtrl[1] = mCtrl[0];
         mWreg[1] = mWreg[0];
         if (fl || hz) begin
            mCtrl[0] = 12'h000;
            mWreg[0] = 5'd0;
            mOp      = 6'd0;
         end else begin
            mCtrl[0] = dec;
            mWreg[0] = wr;
            mOp      = (dec == 12'h000) ? 6'd0 : op;
            if (v && (refDecode(op) == 12'h000) && (mIll < 255)) mIll++;
         end
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Asserts reset between edges, checks the immediate clear, then releases after the next edge
   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      modelClear();
      compareAll(1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] opTab [10];
      logic [5:0] op;
      opTab = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h3f, 6'h00};
      rst_n    = 1'b0;
      idValid  = 1'b0;
      idOpcode = 6'd0;
      idRs     = 5'd0;
      idRt     = 5'd0;
      idRd     = 5'd0;
      stallExt = 1'b0;
      flushIn  = 1'b0;
      modelClear();
      #12;
      compareAll(1'b0);
      rst_n = 1'b1;

      // T1: reset in the middle of traffic, then a load right after release
      applyStimulus(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h23, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h3f, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      doReset();
      applyStimulus(1'b1, 6'h23, 5'd2, 5'd9, 5'd0, 1'b0, 1'b0);
      idle();
      checkOutput("T1 ctrl_ex lw", 32'(ctrlEx), 32'h780);

      // T2: load-use hazard inserts exactly one bubble
      applyStimulus(1'b1, 6'h23, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h00, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
      checkOutput("T2 stall_id set", 32'(stallId), 32'd1);
      applyStimulus(1'b1, 6'h00, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
      checkOutput("T2 stall_id clear", 32'(stallId), 32'd0);
      checkOutput("T2 ctrl_ex bubble", 32'(ctrlEx), 32'h000);
      idle();
      checkOutput("T2 ctrl_ex R", 32'(ctrlEx), 32'h908);
      checkOutput("T2 ctrl_wb lw", 32'(ctrlWb), 32'h780);
      idle();
      checkOutput("T2 ctrl_wb bubble", 32'(ctrlWb), 32'h000);
      idle();
      checkOutput("T2 ctrl_wb R", 32'(ctrlWb), 32'h908);

      // T3: register 0 never stalls
      applyStimulus(1'b1, 6'h23, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h00, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("T3 stall_id", 32'(stallId), 32'd0);
      idle();
      checkOutput("T3 ctrl_ex R", 32'(ctrlEx), 32'h908);

      // T4: flush beats hazard; memory stall freezes every stage
      applyStimulus(1'b1, 6'h23, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h00, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1);
      checkOutput("T4 stall_id flush", 32'(stallId), 32'd0);
      idle();
      checkOutput("T4 ctrl_ex flush", 32'(ctrlEx), 32'h000);
      applyStimulus(1'b1, 6'h23, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h00, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h2b, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6'h23, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
         checkOutput("T4 hold ctrl_ex", 32'(ctrlEx), 32'h440);
         checkOutput("T4 hold ctrl_mem", 32'(ctrlMem), 32'h908);
         checkOutput("T4 hold ctrl_wb", 32'(ctrlWb), 32'h780);
      end

      // T5: jal forces the link register; sw does not write
      applyStimulus(1'b1, 6'h03, 5'd0, 5'd2, 5'd7, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h2b, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
      checkOutput("T5 ex_wreg jal", 32'(exWreg), 32'd31);
      checkOutput("T5 ctrl_ex jal", 32'(ctrlEx), 32'h103);
      idle();
      checkOutput("T5 ctrl_ex sw", 32'(ctrlEx), 32'h440);
      checkOutput("T5 RegWrite sw", 32'(ctrlEx[8]), 32'd0);

      // T6: illegal-opcode counter saturation, then the immediate-op option
      doReset();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 6'h3f, 5'($urandom_range(31)), 5'($urandom_range(31)),
                       5'($urandom_range(31)), 1'b0, 1'b0);
      end
      idle();
      checkOutput("T6 ill_cnt saturated", 32'(illCnt), 32'd255);
      doReset();
      applyStimulus(1'b1, 6'h08, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
      idle();
`ifdef EXT_IMM_OPS_EN
      checkOutput("T6 addi ctrl_ex", 32'(ctrlEx), 32'h50c);
      checkOutput("T6 addi ex_wreg", 32'(exWreg), 32'd6);
      checkOutput("T6 addi ill_cnt", 32'(illCnt), 32'd0);
`else
      checkOutput("T6 addi ctrl_ex", 32'(ctrlEx), 32'h000);
      checkOutput("T6 addi ill_cnt", 32'(illCnt), 32'd1);
`endif

      // Randomized traffic with small register indices so hazards are frequent
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) == 0) doReset();
         op = opTab[$urandom_range(9)];
         if ($urandom_range(9) == 9) op = 6'($urandom_range(63));
         applyStimulus($urandom_range(9) != 0, op, 5'($urandom_range(3)), 5'($urandom_range(3)),
                       5'($urandom_range(3)), $urandom_range(9) == 0, $urandom_range(9) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
